// File: rtl/serial_frame_rx.sv
// Bit-serial frame receiver: start bit 0, WIDTH data bits LSB-first, stop bit 1,
// one bit per clock. Good frames update Data with a Valid pulse; bad stops pulse Error.
module serial_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             x,
    output logic [WIDTH-1:0] Data,
    output logic             Valid,
    output logic             Error,
    output logic             Busy,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] shift_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shift_q <= '0;
            Data    <= '0;
            Valid   <= 1'b0;
            Error   <= 1'b0;
        end else begin
            Valid <= 1'b0;
            Error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!x) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    // Decoded write avoids an oversized bit-select index.
                    for (int i = 0; i < WIDTH; i++) begin
                        if (cnt == CW'(i)) shift_q[i] <= x;
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) state <= STOP;
                end
                STOP: begin
                    // A 0 stop bit is only an error; it never doubles as a start bit.
                    if (x) begin
                        Data  <= shift_q;
                        Valid <= 1'b1;
                    end else begin
                        Error <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=8): reset, single and back-to-back
// frames, framing error, reset mid-frame and a line stuck low.
module tb_serial_frame_rx;

    localparam int W = 8;

    logic         Clock;
    logic         Reset;
    logic         x;
    logic [W-1:0] Data;
    logic         Valid;
    logic         Error;
    logic         Busy;
    logic [1:0]   state_dbg;

    int n_total = 0;
    int n_bad   = 0;
    logic [W-1:0] exp_q[$];

    serial_frame_rx #(.WIDTH(W)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .x         (x),
        .Data      (Data),
        .Valid     (Valid),
        .Error     (Error),
        .Busy      (Busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one bit, let the DUT sample it, then settle just past the edge.
    task automatic send_bit(input logic b);
        x = b;
        @(posedge Clock);
        #1;
    endtask

    // Start bit plus data bits; leaves the stop bit to the caller.
    task automatic send_head(input logic [W-1:0] d);
        send_bit(1'b0);
        check("busy_after_start", Busy, 1'b1);
        for (int i = 0; i < W; i++) send_bit(d[i]);
        check("busy_before_stop", Busy, 1'b1);
        check("no_valid_in_frame", Valid, 1'b0);
    endtask

    task automatic good_frame(input logic [W-1:0] d);
        send_head(d);
        exp_q.push_back(d);
        send_bit(1'b1);
        check("valid_on_stop", Valid, 1'b1);
        check("error_on_good", Error, 1'b0);
        check("data_on_stop", Data, exp_q.pop_front());
        check("busy_after_stop", Busy, 1'b0);
    endtask

    logic seen;

    initial begin
        Reset = 1'b1;
        x     = 1'b1;

        // reset with x toggling
        send_bit(1'b0);
        send_bit(1'b1);
        check("rst_data", Data, 8'h00);
        check("rst_valid", Valid, 1'b0);
        check("rst_error", Error, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_state", state_dbg, 2'd0);

        Reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            send_bit(1'b1);
            if (Valid || Error || Busy || Data != 8'h00) seen = 1'b1;
        end
        check("idle_quiet", seen, 1'b0);

        // single frame
        good_frame(8'hA5);
        send_bit(1'b1);
        check("valid_one_cycle", Valid, 1'b0);
        check("data_hold", Data, 8'hA5);

        // back-to-back frames, no idle bit between
        good_frame(8'h3C);
        send_bit(1'b0);
        check("b2b_valid_drop", Valid, 1'b0);
        check("b2b_busy_again", Busy, 1'b1);
        for (int i = 0; i < W; i++) send_bit(1'(8'hC3 >> i));
        exp_q.push_back(8'hC3);
        send_bit(1'b1);
        check("b2b_valid2", Valid, 1'b1);
        check("b2b_data2", Data, exp_q.pop_front());

        // framing error
        send_head(8'h5A);
        send_bit(1'b0);
        check("ferr_error", Error, 1'b1);
        check("ferr_valid", Valid, 1'b0);
        check("ferr_data", Data, 8'hC3);
        check("ferr_state", state_dbg, 2'd0);
        send_bit(1'b1);
        check("ferr_no_restart", Busy, 1'b0);
        check("ferr_error_drop", Error, 1'b0);

        // reset mid-frame
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        Reset = 1'b1;
        send_bit(1'b1);
        Reset = 1'b0;
        check("mid_rst_data", Data, 8'h00);
        check("mid_rst_busy", Busy, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            send_bit(1'b1);
            if (Valid || Error || Busy) seen = 1'b1;
        end
        check("mid_rst_quiet", seen, 1'b0);
        good_frame(8'h81);

        // reset on the same edge as a stop bit
        send_head(8'h66);
        Reset = 1'b1;
        send_bit(1'b1);
        Reset = 1'b0;
        check("rst_stop_valid", Valid, 1'b0);
        check("rst_stop_data", Data, 8'h00);

        // line stuck low after reset
        Reset = 1'b1;
        send_bit(1'b0);
        Reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            send_bit(1'b0);
            check($sformatf("stuck_err_%0d", k), Error, (k % 10 == 9) ? 1'b1 : 1'b0);
            check($sformatf("stuck_val_%0d", k), Valid, 1'b0);
        end
        check("stuck_data", Data, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
